// File: rtl/spi_pkg.sv
// Shared state encoding, SPI mode constants and default sizing for the
// SPI transmit serializer and its clock generator.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SHIFT,
    GAP
  } spi_state_t;

  // Mode 0: SCLK idles low, data is sampled on the leading (rising) edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CLK_DIV    = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: holds each SCLK level for CLK_DIV clk cycles while enabled and
// flags the cycle whose closing clk edge will toggle SCLK.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             phase_end;

  // Strobes lead the SCLK register by one cycle so the datapath can act on
  // the same clk edge that moves the pin.
  assign phase_end = en && (div_cnt == DIV_LAST);
  assign rise      = phase_end && !sclk;
  assign fall      = phase_end && sclk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      sclk    <= CPOL;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_tx_serializer.sv
// SPI mode-0 master: pops words from the TX FIFO, shifts them MSB-first on
// MOSI while capturing MISO, and pushes each captured word into the RX FIFO.
module spi_tx_serializer
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  tx_empty,
  output logic                  tx_rd_en,
  input  logic [DATA_WIDTH-1:0] tx_rd_data,
  input  logic                  rx_full,
  output logic                  rx_wr_en,
  output logic [DATA_WIDTH-1:0] rx_wr_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  done,
  output logic                  rx_overflow
);

  localparam int               BIT_W          = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST       = BIT_W'(DATA_WIDTH - 1);
  localparam int               DIV_W          = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] GAP_LAST       = DIV_W'(CLK_DIV - 1);
  localparam bit               SAMPLE_ON_RISE = (CPHA == 1'b0);

  spi_state_t state, next_state;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      gap_cnt;

  logic shift_en;
  logic sclk_rise;
  logic sclk_fall;
  logic sample_edge;
  logic launch_edge;
  logic word_last;
  logic fetch_ok;

  logic tx_rd_en_d;
  logic rx_wr_en_d;
  logic done_d;
  logic busy_d;
  logic cs_n_d;
  logic overflow_d;

  assign shift_en = (state == SHIFT);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk (clk),
    .rst (rst),
    .en  (shift_en),
    .sclk(sclk),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
  assign launch_edge = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

  // The closing edge of the last bit's high phase is the word-end decision point.
  assign word_last = shift_en && launch_edge && (bit_cnt == BIT_LAST);
  assign fetch_ok  = enable && !tx_empty;

  // The shift register's MSB is the bit currently on the wire.
  assign mosi = shift_reg[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fetch_ok) next_state = FETCH;
      FETCH:   next_state = LATCH;
      LATCH:   next_state = SHIFT;
      SHIFT:   if (word_last) next_state = fetch_ok ? FETCH : GAP;
      GAP:     if (gap_cnt == GAP_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next-cycle values of the control outputs; they are registered below so
  // no input reaches a pin without passing through a flop.
  always_comb begin
    tx_rd_en_d = (next_state == FETCH);
    busy_d     = (next_state != IDLE);
    done_d     = word_last;
    rx_wr_en_d = word_last && !rx_full;
    overflow_d = rx_overflow || (word_last && rx_full);
    cs_n_d     = cs_n;
    if (state == LATCH) begin
      cs_n_d = 1'b0;
    end else if (word_last && (next_state == GAP)) begin
      cs_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rd_en    <= 1'b0;
      rx_wr_en    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      cs_n        <= 1'b1;
      rx_overflow <= 1'b0;
      rx_wr_data  <= '0;
    end else begin
      tx_rd_en    <= tx_rd_en_d;
      rx_wr_en    <= rx_wr_en_d;
      done        <= done_d;
      busy        <= busy_d;
      cs_n        <= cs_n_d;
      rx_overflow <= overflow_d;
      if (rx_wr_en_d) begin
        rx_wr_data <= rx_shift;
      end
    end
  end

  // Shift datapath; the last bit is not shifted out so MOSI holds it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + DIV_W'(1) : '0;
      if (state == LATCH) begin
        shift_reg <= tx_rd_data;
        rx_shift  <= '0;
        bit_cnt   <= '0;
      end else begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
        end
        if (launch_edge && (bit_cnt != BIT_LAST)) begin
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Bench for spi_tx_serializer with a TX FIFO model, a mode-0 SPI slave model
// and scoreboards for the words seen on MOSI and pushed into the RX FIFO.
module tb_spi_tx_serializer;

  localparam int W   = 32;
  localparam int DIV = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         tx_empty;
  logic         tx_rd_en;
  logic [W-1:0] tx_rd_data;
  logic         rx_full;
  logic         rx_wr_en;
  logic [W-1:0] rx_wr_data;
  logic         sclk;
  logic         mosi;
  logic         miso;
  logic         cs_n;
  logic         busy;
  logic         done;
  logic         rx_overflow;

  logic loopback;
  logic miso_drv;

  assign miso = loopback ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_tx_serializer #(
    .DATA_WIDTH(W),
    .CLK_DIV   (DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tx_empty   (tx_empty),
    .tx_rd_en   (tx_rd_en),
    .tx_rd_data (tx_rd_data),
    .rx_full    (rx_full),
    .rx_wr_en   (rx_wr_en),
    .rx_wr_data (rx_wr_data),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs_n       (cs_n),
    .busy       (busy),
    .done       (done),
    .rx_overflow(rx_overflow)
  );

  logic [W-1:0] tx_fifo[$];
  logic [W-1:0] exp_mosi[$];
  logic [W-1:0] exp_rx[$];
  logic [W-1:0] popped;
  logic [W-1:0] slave_word;
  logic [W-1:0] mosi_word;
  logic         pop_pending;
  logic         prev_sclk;
  logic         prev_cs_n;

  int checks, errors, cycle;
  int rd_pulses, done_pulses, rxwr_pulses, cs_rises, mosi_bits;
  int last_rise, low_run, first_low, rd_cycle, cs_fall_cycle, cs_rise_cycle;
  int rd0, d0, r0, cs0, bad;

  task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
    end
  endtask

  // One clk cycle, evaluated at the falling edge: FIFO model, slave model, monitors.
  task automatic tick();
    @(negedge clk);
    cycle++;
    if (pop_pending) begin
      tx_rd_data  = popped;
      pop_pending = 1'b0;
    end else begin
      tx_rd_data = 32'hDEAD_BEEF;
    end
    if (tx_rd_en) begin
      rd_pulses++;
      rd_cycle = cycle;
      checkOutput("rd_while_empty", {31'd0, tx_empty}, 32'd0);
      if (tx_fifo.size() > 0) begin
        popped      = tx_fifo.pop_front();
        pop_pending = 1'b1;
      end
    end
    tx_empty = (tx_fifo.size() == 0);

    if (sclk && !prev_sclk) begin
      if (mosi_bits == 0) first_low = low_run;
      else checkOutput("sclk_period", cycle - last_rise, 2 * DIV);
      last_rise = cycle;
      mosi_word = {mosi_word[W-2:0], mosi};
      mosi_bits++;
    end
    low_run = sclk ? 0 : low_run + 1;

    if (!cs_n && prev_cs_n) cs_fall_cycle = cycle;
    if (cs_n && !prev_cs_n) begin
      cs_rises++;
      cs_rise_cycle = cycle;
    end

    if (done) begin
      done_pulses++;
      checkOutput("rise_count", mosi_bits, W);
      if (exp_mosi.size() == 0) checkOutput("unexpected_done", 32'd1, 32'd0);
      else checkOutput("mosi_word", mosi_word, exp_mosi.pop_front());
      mosi_bits = 0;
    end
    if (rx_wr_en) begin
      rxwr_pulses++;
      if (exp_rx.size() == 0) checkOutput("unexpected_rx_wr", 32'd1, 32'd0);
      else checkOutput("rx_word", rx_wr_data, exp_rx.pop_front());
    end

    miso_drv  = (mosi_bits < W) ? slave_word[W-1-mosi_bits] : 1'b0;
    prev_sclk = sclk;
    prev_cs_n = cs_n;
  endtask

  task automatic applyStimulus(input logic [W-1:0] word, input bit expect_word,
                               input bit expect_rx, input logic [W-1:0] rx_word);
    tx_fifo.push_back(word);
    if (expect_word) exp_mosi.push_back(word);
    if (expect_rx) exp_rx.push_back(rx_word);
    tx_empty = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (!((done_pulses >= target) && !busy) && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, (done_pulses >= target) && !busy}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tx_empty = 1'b1; rx_full = 1'b0;
    loopback = 1'b0; miso_drv = 1'b0; tx_rd_data = '0;
    slave_word = '0; mosi_word = '0; popped = '0;
    pop_pending = 1'b0; prev_sclk = 1'b0; prev_cs_n = 1'b1;
    checks = 0; errors = 0; cycle = 0;
    rd_pulses = 0; done_pulses = 0; rxwr_pulses = 0; cs_rises = 0; mosi_bits = 0;
    last_rise = 0; low_run = 0; first_low = 0; rd_cycle = 0;
    cs_fall_cycle = 0; cs_rise_cycle = 0; bad = 0;

    repeat (3) tick();
    checkOutput("reset_ctrl", {24'd0, sclk, cs_n, mosi, tx_rd_en, rx_wr_en, busy, done,
                rx_overflow}, 32'h0000_0040);
    checkOutput("reset_rx_data", rx_wr_data, 32'd0);
    rst = 1'b0;
    tick();

    // Single word with an independent slave pattern on MISO.
    enable = 1'b1;
    slave_word = 32'h3C3C_96E1;
    rd0 = rd_pulses; d0 = done_pulses; r0 = rxwr_pulses;
    applyStimulus(32'hA5A5_0F0F, 1'b1, 1'b1, 32'h3C3C_96E1);
    waitDone("t1_wait", d0 + 1, 400);
    checkOutput("t1_rd_pulses", rd_pulses - rd0, 1);
    checkOutput("t1_cs_fall_delay", cs_fall_cycle - rd_cycle, 2);
    checkOutput("t1_cs_low_cycles", cs_rise_cycle - cs_fall_cycle, 2 * DIV * W);
    checkOutput("t1_done_pulses", done_pulses - d0, 1);
    checkOutput("t1_rx_pulses", rxwr_pulses - r0, 1);

    // Loopback.
    loopback = 1'b1;
    d0 = done_pulses; r0 = rxwr_pulses;
    applyStimulus(32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678);
    waitDone("t2_wait", d0 + 1, 400);
    checkOutput("t2_rx_pulses", rxwr_pulses - r0, 1);
    checkOutput("t2_overflow", {31'd0, rx_overflow}, 32'd0);

    // Two-word burst with chip select held.
    rd0 = rd_pulses; d0 = done_pulses; cs0 = cs_rises;
    applyStimulus(32'hFFFF_0000, 1'b1, 1'b1, 32'hFFFF_0000);
    applyStimulus(32'h0000_FFFF, 1'b1, 1'b1, 32'h0000_FFFF);
    waitDone("t3_wait", d0 + 2, 800);
    checkOutput("t3_rd_pulses", rd_pulses - rd0, 2);
    checkOutput("t3_done_pulses", done_pulses - d0, 2);
    checkOutput("t3_cs_rises", cs_rises - cs0, 1);
    checkOutput("t3_interword_low", first_low, DIV + 2);

    // RX FIFO full: word dropped, sticky overflow.
    loopback = 1'b0;
    slave_word = 32'h5555_AAAA;
    rx_full = 1'b1;
    d0 = done_pulses; r0 = rxwr_pulses;
    applyStimulus(32'h0BAD_F00D, 1'b1, 1'b0, 32'd0);
    waitDone("t4_wait", d0 + 1, 400);
    checkOutput("t4_rx_pulses", rxwr_pulses - r0, 0);
    checkOutput("t4_overflow_set", {31'd0, rx_overflow}, 32'd1);
    rx_full = 1'b0;
    repeat (5) tick();
    checkOutput("t4_overflow_sticky", {31'd0, rx_overflow}, 32'd1);
    loopback = 1'b1;
    d0 = done_pulses; r0 = rxwr_pulses;
    applyStimulus(32'h0F0F_1234, 1'b1, 1'b1, 32'h0F0F_1234);
    waitDone("t4b_wait", d0 + 1, 400);
    checkOutput("t4b_rx_pulses", rxwr_pulses - r0, 1);
    checkOutput("t4b_overflow_kept", {31'd0, rx_overflow}, 32'd1);

    // Reset in the middle of a word.
    d0 = done_pulses; r0 = rxwr_pulses;
    applyStimulus(32'hCAFE_F00D, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 300 && mosi_bits != 10; i++) tick();
    checkOutput("t5_reach_bit10", mosi_bits, 10);
    rst = 1'b1;
    tick();
    checkOutput("t5_reset_pins", {28'd0, sclk, cs_n, mosi, busy}, 32'h0000_0004);
    rst = 1'b0;
    mosi_bits = 0;
    repeat (150) tick();
    checkOutput("t5_no_done", done_pulses - d0, 0);
    checkOutput("t5_no_rx_wr", rxwr_pulses - r0, 0);
    checkOutput("t5_overflow_cleared", {31'd0, rx_overflow}, 32'd0);

    // Enabled with an empty TX FIFO.
    enable = 1'b1;
    rd0 = rd_pulses;
    bad = 0;
    repeat (100) begin
      tick();
      if (busy || !cs_n) bad++;
    end
    checkOutput("t6_no_rd", rd_pulses - rd0, 0);
    checkOutput("t6_idle_pins", bad, 0);

    checkOutput("left_mosi_words", exp_mosi.size(), 0);
    checkOutput("left_rx_words", exp_rx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
